sprite_fetch_ctrl: RTL and testbench

Sequences the shared 6-bit sprite ROM for the duck layer: turns the VGA timing counters into a ROM address stream and a `draw` strobe aligned with the ROM's registered data. It owns the sprite position and animation frame, double-buffered so that game logic updates take effect only at a frame boundary. It sits between VGA_LOGIC's hcount/vcount and the sprite ROM, in the `vga_clk` domain, and feeds the drawer's pixel mux.

---
 rtl/sprite_fetch_ctrl_pkg.sv | 23 ++
 rtl/sprite_fetch_ctrl_shadow.sv | 44 ++++
 rtl/sprite_fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_sprite_fetch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sprite_fetch_ctrl_pkg.sv
// Shared constants and types for the duck-layer sprite fetch controller.
package sprite_fetch_ctrl_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int SPR_W      = 124;
  localparam int SPR_H      = 162;
  localparam int FRAME_SIZE = SPR_W * SPR_H;

  typedef enum logic [1:0] {
    WAIT_TOP  = 2'd0,
    IN_SPRITE = 2'd1,
    DONE      = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       frame;
    logic       en;
  } sprite_pos_t;

endpackage

// File: rtl/sprite_fetch_ctrl_shadow.sv
// Shadow/active sprite position registers with a valid/ready update port.
// Updates land in the shadow and are copied to the active set only on commit.
module sprite_pos_shadow
  import sprite_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  sprite_pos_t req,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        commit,
  output logic [9:0]  act_x,
  output logic [9:0]  act_y,
  output logic        act_en,
  output logic        next_frame
);

  sprite_pos_t shadow;
  sprite_pos_t active;
  logic        full;

  // Capture an update into the empty shadow, or promote a full shadow at commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
      full   <= 1'b0;
    end else if (commit && full) begin
      active <= shadow;
      full   <= 1'b0;
    end else if (req_valid && !full) begin
      shadow <= req;
      full   <= 1'b1;
    end
  end

  assign req_ready  = !full;
  assign act_x      = active.x;
  assign act_y      = active.y;
  assign act_en     = active.en;
  // Frame that will be active once the current commit has taken effect.
  assign next_frame = full ? shadow.frame : active.frame;

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Turns VGA counters into a sprite ROM address stream plus a draw strobe
// aligned with the ROM's registered output (two cycles after the pixel).
module sprite_fetch_ctrl #(
  parameter int SPR_W    = sprite_fetch_ctrl_pkg::SPR_W,
  parameter int SPR_H    = sprite_fetch_ctrl_pkg::SPR_H,
  parameter int H_ACTIVE = sprite_fetch_ctrl_pkg::H_ACTIVE,
  parameter int V_ACTIVE = sprite_fetch_ctrl_pkg::V_ACTIVE,
  parameter int ADDR_W   = 16
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_frame,
  input  logic              pos_en,
  input  logic              pos_valid,
  output logic              pos_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              draw,
  output logic              frame_tick
);

  import sprite_fetch_ctrl_pkg::*;

  localparam logic [10:0]       H_END        = 11'(H_ACTIVE);
  localparam logic [10:0]       V_END        = 11'(V_ACTIVE);
  localparam logic [10:0]       SPR_W11      = 11'(SPR_W);
  localparam logic [10:0]       LAST_ROW_OFS = 11'(SPR_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] FRAME_BASE   = ADDR_W'(SPR_W * SPR_H);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] row_base_next;
  logic [ADDR_W-1:0] pix_addr;
  logic              hit_d;

  sprite_pos_t       req;
  logic [9:0]        act_x;
  logic [9:0]        act_y;
  logic              act_en;
  logic              next_frame;

  logic [10:0]       h11;
  logic [10:0]       v11;
  logic [10:0]       x11;
  logic [10:0]       y11;
  logic              commit;
  logic              line_end;
  logic              direct_entry;
  logic              in_sprite;
  logic              hit;

  assign req = '{x: pos_x, y: pos_y, frame: pos_frame, en: pos_en};

  sprite_pos_shadow u_shadow (
    .clk        (vga_clk),
    .reset      (reset),
    .req        (req),
    .req_valid  (pos_valid),
    .req_ready  (pos_ready),
    .commit     (commit),
    .act_x      (act_x),
    .act_y      (act_y),
    .act_en     (act_en),
    .next_frame (next_frame)
  );

  // All comparisons run at 11 bits so x+SPR_W and vcount+1 cannot wrap.
  assign h11 = {1'b0, hcount};
  assign v11 = {1'b0, vcount};
  assign x11 = {1'b0, act_x};
  assign y11 = {1'b0, act_y};

  assign commit   = (h11 == 11'd0) && (v11 == V_END);
  assign line_end = (h11 == H_END);

  // A sprite at y==0 has no preceding line end to arm it after commit, so it
  // is entered at the very start of its first line instead.
  assign direct_entry = (state == WAIT_TOP) && (h11 == 11'd0) && (v11 == y11) && !commit;
  assign in_sprite    = (state == IN_SPRITE) || direct_entry;

  assign hit = in_sprite && act_en &&
               (h11 >= x11) && (h11 < x11 + SPR_W11) &&
               (h11 < H_END) && (v11 < V_END);

  assign pix_addr = row_base + ADDR_W'(h11 - x11);

  // Next-state and row-base update: commit restarts, line ends advance.
  always_comb begin
    state_next    = state;
    row_base_next = row_base;
    if (commit) begin
      state_next    = WAIT_TOP;
      row_base_next = next_frame ? FRAME_BASE : '0;
    end else begin
      case (state)
        WAIT_TOP: begin
          if (direct_entry) begin
            state_next = IN_SPRITE;
          end else if (line_end && (v11 + 11'd1 == y11)) begin
            state_next = IN_SPRITE;
          end
        end
        IN_SPRITE: begin
          if (line_end) begin
            row_base_next = row_base + ROW_STEP;
            if (v11 == y11 + LAST_ROW_OFS) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = WAIT_TOP;
        end
      endcase
    end
  end

  // Sequencer state and current sprite row base.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state    <= WAIT_TOP;
      row_base <= '0;
    end else begin
      state    <= state_next;
      row_base <= row_base_next;
    end
  end

  // Two-stage alignment: address and hit first, then draw with the ROM data.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr <= '0;
      hit_d    <= 1'b0;
      draw     <= 1'b0;
    end else begin
      hit_d <= hit;
      draw  <= hit_d;
      if (hit) begin
        rom_addr <= pix_addr;
      end
    end
  end

  assign frame_tick = commit && !reset;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Self-checking bench for sprite_fetch_ctrl using a reduced raster so many
// frames fit in a short run; expectations come from a geometric sprite model.
module tb_sprite_fetch_ctrl;

  localparam int SPR_W     = 12;
  localparam int SPR_H     = 6;
  localparam int H_ACTIVE  = 40;
  localparam int V_ACTIVE  = 24;
  localparam int ADDR_W    = 8;
  localparam int H_TOTAL   = 48;
  localparam int V_TOTAL   = 28;
  localparam int FRAMES    = 24;
  localparam int RST_FRAME = 6;
  localparam int RST_V     = 8;
  localparam int RST_H     = 15;

  logic              vga_clk = 1'b0;
  logic              reset;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              pos_frame;
  logic              pos_en;
  logic              pos_valid;
  logic              pos_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic              draw;
  logic              frame_tick;

  sprite_fetch_ctrl #(
    .SPR_W    (SPR_W),
    .SPR_H    (SPR_H),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_frame  (pos_frame),
    .pos_en     (pos_en),
    .pos_valid  (pos_valid),
    .pos_ready  (pos_ready),
    .rom_addr   (rom_addr),
    .draw       (draw),
    .frame_tick (frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  int compared   = 0;
  int mismatched = 0;
  int tick_count = 0;

  // Directed updates issued in frames 0..5; each becomes visible one frame later.
  int tbl_x  [6] = '{5, 5, 35, 0, 8, 12};
  int tbl_y  [6] = '{3, 3, 21, 0, 4, 6};
  int tbl_fr [6] = '{0, 1, 0, 1, 0, 0};
  int tbl_en [6] = '{1, 1, 1, 1, 0, 1};

  // Reference model: committed sprite geometry plus a pending request.
  int act_x = 0, act_y = 0, act_f = 0, act_en = 0;
  int sh_x = 0, sh_y = 0, sh_f = 0, sh_en = 0;
  bit sh_full  = 1'b0;
  bit hit_prev = 1'b0;
  int exp_draw = 0, exp_addr = 0, exp_ready = 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (h=%0d v=%0d t=%0t)",
               tag, actual, expected, hcount, vcount, $time);
    end
  endtask

  task automatic modelStep();
    int h;
    int v;
    bit hit;
    h = int'(hcount);
    v = int'(vcount);
    if (reset) begin
      act_x = 0; act_y = 0; act_f = 0; act_en = 0;
      sh_full  = 1'b0;
      hit_prev = 1'b0;
      exp_draw = 0;
      exp_addr = 0;
    end else begin
      hit = (act_en != 0) && (v >= act_y) && (v < act_y + SPR_H) &&
            (h >= act_x) && (h < act_x + SPR_W) && (h < H_ACTIVE) && (v < V_ACTIVE);
      exp_draw = int'(hit_prev);
      hit_prev = hit;
      if (hit) begin
        exp_addr = (act_f * SPR_W * SPR_H + (v - act_y) * SPR_W + (h - act_x)) % (1 << ADDR_W);
      end
      if (h == 0 && v == V_ACTIVE && sh_full) begin
        act_x = sh_x; act_y = sh_y; act_f = sh_f; act_en = sh_en;
        sh_full = 1'b0;
      end else if (pos_valid && !sh_full) begin
        sh_x = int'(pos_x); sh_y = int'(pos_y); sh_f = int'(pos_frame); sh_en = int'(pos_en);
        sh_full = 1'b1;
      end
    end
    exp_ready = sh_full ? 0 : 1;
  endtask

  task automatic applyStimulus(input int f, input int v, input int h);
    hcount    = 10'(h);
    vcount    = 10'(v);
    reset     = (f == RST_FRAME && v == RST_V && h == RST_H);
    pos_valid = 1'b0;
    if (f < 6) begin
      if (v == 1 && h == 2) begin
        pos_x     = 10'(tbl_x[f]);
        pos_y     = 10'(tbl_y[f]);
        pos_frame = 1'(tbl_fr[f]);
        pos_en    = 1'(tbl_en[f]);
        pos_valid = 1'b1;
      end
      if (f == 3 && v == 5 && h == 2) begin
        pos_x     = 10'd20;
        pos_y     = 10'd8;
        pos_frame = 1'b0;
        pos_en    = 1'b1;
        pos_valid = 1'b1;
      end
    end else if (f >= 8) begin
      if ($urandom_range(0, 3) == 0) pos_x = 10'(H_ACTIVE - int'($urandom_range(1, SPR_W)));
      else                           pos_x = 10'($urandom_range(0, H_ACTIVE - 1));
      if ($urandom_range(0, 3) == 0) pos_y = 10'(V_ACTIVE - int'($urandom_range(1, SPR_H)));
      else                           pos_y = 10'($urandom_range(0, V_ACTIVE - 1));
      pos_frame = 1'($urandom_range(0, 1));
      pos_en    = ($urandom_range(0, 4) != 0);
      pos_valid = ($urandom_range(0, 149) == 0);
    end
  endtask

  task automatic stepCycle();
    @(posedge vga_clk);
    modelStep();
    @(negedge vga_clk);
    checkOutput("draw", 32'(draw), 32'(exp_draw));
    checkOutput("rom_addr", 32'(rom_addr), 32'(exp_addr));
    checkOutput("pos_ready", 32'(pos_ready), 32'(exp_ready));
    checkOutput("frame_tick", 32'(frame_tick),
                32'((hcount == 10'd0 && vcount == 10'(V_ACTIVE) && !reset) ? 1 : 0));
    tick_count += int'(frame_tick);
  endtask

  initial begin
    reset     = 1'b1;
    hcount    = 10'd0;
    vcount    = 10'(V_TOTAL - 1);
    pos_x     = '0;
    pos_y     = '0;
    pos_frame = 1'b0;
    pos_en    = 1'b0;
    pos_valid = 1'b0;
    repeat (3) stepCycle();
    tick_count = 0;

    for (int f = 0; f < FRAMES; f++) begin
      for (int v = 0; v < V_TOTAL; v++) begin
        for (int h = 0; h < H_TOTAL; h++) begin
          applyStimulus(f, v, h);
          stepCycle();
        end
      end
      checkOutput("ticks_per_frame", 32'(tick_count), 32'd1);
      tick_count = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
